// File: rtl/counter_mcx.sv
// ============================================================================
//  Module   : counter_mcx
//  Summary  : CH-channel W-bit one-shot / periodic / PWM counter with IRQ.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module counter_mcx #(
    parameter int CH = 3,
    parameter int W  = 32,
    parameter int CW = 2
) (
    input  logic          clk,
    input  logic          RSTN,
    input  logic          counter_we,
    input  logic [CW-1:0] counter_ch,
    input  logic [W-1:0]  counter_val,
    input  logic [CH-1:0] tick,
    input  logic [CH-1:0] irq_clr,
    input  logic [CW-1:0] rd_ch,
    output logic [W-1:0]  counter_out,
    output logic [CH-1:0] counter_OUT,
    output logic          irq
);

    localparam logic [CW-1:0] c_CTRL_SEL = CW'(CH);
    localparam int            c_HW       = W / 2;
    localparam int            c_CB       = 4 * CH;

    logic [c_CB-1:0] r_ctrl;
    logic [c_CB-1:0] w_ctrl_nxt;
    logic            w_ctrl_wr;
    logic [CH-1:0]   w_pend;
    logic [CH-1:0]   w_pend_nxt;
    logic [CH-1:0]   w_ie_nxt;
    logic [W-1:0]    w_count [CH];
    logic            r_irq;

    assign w_ctrl_wr  = counter_we && (counter_ch == c_CTRL_SEL);
    assign w_ctrl_nxt = w_ctrl_wr ? counter_val[c_CB-1:0] : r_ctrl;

    for (genvar i = 0; i < CH; i++) begin : g_ch
        localparam logic [CW-1:0] c_SEL = CW'(i);

        logic [W-1:0] r_count;
        logic [W-1:0] r_reload;
        logic [W-1:0] w_count_nxt;
        logic [W-1:0] w_p;
        logic [W-1:0] w_d;
        logic         r_out;
        logic         r_pend;
        logic         r_tick_q;
        logic         w_out_nxt;
        logic         w_set;
        logic         w_ev;
        logic         w_wr;
        logic         w_en;
        logic         w_mode_chg;
        logic [1:0]   w_mode_old;
        logic [1:0]   w_mode_new;

        assign w_wr       = counter_we && (counter_ch == c_SEL);
        assign w_mode_old = r_ctrl[4*i+1 +: 2];
        assign w_mode_new = w_ctrl_nxt[4*i+1 +: 2];
        assign w_en       = w_ctrl_nxt[4*i];
        assign w_ev       = w_en & tick[i] & ~r_tick_q;
        assign w_mode_chg = (w_mode_old != w_mode_new);
        assign w_p        = W'(r_reload[c_HW-1:0]);
        assign w_d        = W'(r_reload[W-1:c_HW]);

        // Mode-change reset forms the base value; a coincident tick then acts on it.
        always_comb begin
            w_count_nxt = r_count;
            w_out_nxt   = r_out;
            w_set       = 1'b0;
            if (w_wr) begin
                w_count_nxt = (w_mode_old == 2'b10) ? '0 : counter_val;
                w_out_nxt   = 1'b0;
            end else begin
                if (w_mode_chg) begin
                    w_count_nxt = (w_mode_new == 2'b10) ? '0 : r_reload;
                    w_out_nxt   = 1'b0;
                end
                if (w_ev) begin
                    case (w_mode_new)
                        2'b00: begin
                            if (w_count_nxt > W'(1)) begin
                                w_count_nxt = w_count_nxt - W'(1);
                            end else if (w_count_nxt == W'(1)) begin
                                w_count_nxt = '0;
                                w_out_nxt   = 1'b1;
                                w_set       = 1'b1;
                            end
                        end
                        2'b01: begin
                            if (r_reload != '0) begin
                                if (w_count_nxt > W'(1)) begin
                                    w_count_nxt = w_count_nxt - W'(1);
                                end else begin
                                    w_count_nxt = r_reload;
                                    w_out_nxt   = ~w_out_nxt;
                                    w_set       = 1'b1;
                                end
                            end
                        end
                        2'b10: begin
                            if (w_p != '0) begin
                                if (w_count_nxt == w_p - W'(1)) begin
                                    w_count_nxt = '0;
                                    w_set       = 1'b1;
                                end else begin
                                    w_count_nxt = w_count_nxt + W'(1);
                                end
                                w_out_nxt = (w_count_nxt < w_d);
                            end
                        end
                        default: begin
                        end
                    endcase
                end
            end
        end

        always_ff @(posedge clk) begin
            if (!RSTN) begin
                r_count  <= '0;
                r_reload <= '0;
                r_out    <= 1'b0;
                r_pend   <= 1'b0;
                r_tick_q <= 1'b0;
            end else begin
                r_count  <= w_count_nxt;
                r_reload <= w_wr ? counter_val : r_reload;
                r_out    <= w_out_nxt;
                r_pend   <= w_pend_nxt[i];
                r_tick_q <= tick[i];
            end
        end

        assign w_pend_nxt[i]  = w_set | (r_pend & ~irq_clr[i]);
        assign w_pend[i]      = r_pend;
        assign w_ie_nxt[i]    = w_ctrl_nxt[4*i+3];
        assign counter_OUT[i] = r_out;
        assign w_count[i]     = r_count;
    end

    always_ff @(posedge clk) begin
        if (!RSTN) begin
            r_ctrl <= '0;
            r_irq  <= 1'b0;
        end else begin
            r_ctrl <= w_ctrl_nxt;
            r_irq  <= |(w_pend_nxt & w_ie_nxt);
        end
    end

    assign irq = r_irq;

    always_comb begin
        counter_out = '0;
        if (rd_ch == c_CTRL_SEL) begin
            counter_out[W-1 -: CH]  = w_pend;
            counter_out[c_CB-1:0]   = r_ctrl;
        end else begin
            for (int k = 0; k < CH; k++) begin
                if (rd_ch == CW'(k)) begin
                    counter_out = w_count[k];
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_counter_mcx.sv
// ============================================================================
//  Module   : tb_counter_mcx
//  Summary  : Directed self-checking bench for counter_mcx.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_counter_mcx;

    logic        clk = 1'b0;
    logic        RSTN;
    logic        counter_we;
    logic [1:0]  counter_ch;
    logic [31:0] counter_val;
    logic [2:0]  tick;
    logic [2:0]  irq_clr;
    logic [1:0]  rd_ch;
    logic [31:0] counter_out;
    logic [2:0]  counter_OUT;
    logic        irq;

    logic        we_hi;
    logic [2:0]  counter_ch3;
    logic        counter_we3;
    logic [2:0]  rd_ch3;
    logic [31:0] counter_out3;
    logic [2:0]  counter_OUT3;
    logic        irq3;

    int n_total = 0;
    int n_pass  = 0;
    int n_pend  = 0;

    always #5 clk = ~clk;

    assign counter_ch3 = we_hi ? 3'd4 : {1'b0, counter_ch};
    assign counter_we3 = counter_we | we_hi;

    counter_mcx #(.CH(3), .W(32), .CW(2)) u_dut (
        .clk(clk), .RSTN(RSTN), .counter_we(counter_we), .counter_ch(counter_ch),
        .counter_val(counter_val), .tick(tick), .irq_clr(irq_clr), .rd_ch(rd_ch),
        .counter_out(counter_out), .counter_OUT(counter_OUT), .irq(irq)
    );

    counter_mcx #(.CH(3), .W(32), .CW(3)) u_dut3 (
        .clk(clk), .RSTN(RSTN), .counter_we(counter_we3), .counter_ch(counter_ch3),
        .counter_val(counter_val), .tick(tick), .irq_clr(irq_clr), .rd_ch(rd_ch3),
        .counter_out(counter_out3), .counter_OUT(counter_OUT3), .irq(irq3)
    );

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic wr(input logic [1:0] ch, input logic [31:0] val);
        counter_we  = 1'b1;
        counter_ch  = ch;
        counter_val = val;
        cyc(1);
        counter_we  = 1'b0;
    endtask

    task automatic pulse(input int ch);
        tick[ch] = 1'b1;
        cyc(1);
        tick[ch] = 1'b0;
        cyc(1);
    endtask

    task automatic clr(input int ch);
        irq_clr[ch] = 1'b1;
        cyc(1);
        irq_clr[ch] = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_c;
        logic        exp_o;

        RSTN = 1'b0; counter_we = 1'b0; counter_ch = '0; counter_val = '0;
        tick = '0; irq_clr = '0; rd_ch = '0; rd_ch3 = '0; we_hi = 1'b0;
        cyc(2);
        RSTN = 1'b1;

        // Scenario 1: one-shot on ch0
        for (int r = 0; r < 4; r++) begin
            rd_ch = 2'(r);
            #1 chk($sformatf("reset_rd%0d", r), counter_out, 32'h0);
        end
        chk("reset_out", {29'h0, counter_OUT}, 32'h0);
        chk("reset_irq", {31'h0, irq}, 32'h0);

        wr(2'd3, 32'h001);
        wr(2'd0, 32'd3);
        rd_ch = 2'd0;
        #1 chk("os_load", counter_out, 32'd3);
        pulse(0); chk("os_t1", counter_out, 32'd2);
        pulse(0); chk("os_t2", counter_out, 32'd1);
        chk("os_out_t2", {31'h0, counter_OUT[0]}, 32'h0);
        pulse(0); chk("os_t3", counter_out, 32'd0);
        chk("os_out_t3", {31'h0, counter_OUT[0]}, 32'h1);
        chk("os_irq_masked", {31'h0, irq}, 32'h0);
        rd_ch = 2'd3;
        #1 chk("os_status", counter_out, 32'h2000_0001);
        pulse(0);
        rd_ch = 2'd0;
        #1 chk("os_t4", counter_out, 32'd0);
        chk("os_out_t4", {31'h0, counter_OUT[0]}, 32'h1);

        wr(2'd3, 32'h009);
        chk("ie_irq", {31'h0, irq}, 32'h1);
        chk("ie_keep_out", {31'h0, counter_OUT[0]}, 32'h1);
        rd_ch = 2'd3;
        #1 chk("rd_status", counter_out, 32'h2000_0009);

        // Wider select build: status at 3, zero above
        rd_ch3 = 3'd3;
        #1 chk("rd3_status", counter_out3, 32'h2000_0009);
        for (int r = 4; r < 8; r++) begin
            rd_ch3 = 3'(r);
            #1 chk($sformatf("rd3_hi%0d", r), counter_out3, 32'h0);
        end
        we_hi = 1'b1; counter_val = 32'hFFFF_FFFF;
        cyc(1);
        we_hi = 1'b0;
        rd_ch3 = 3'd3;
        #1 chk("rd3_ignored_wr", counter_out3, 32'h2000_0009);

        clr(0);
        chk("clr_irq", {31'h0, irq}, 32'h0);
        #1 chk("clr_status", counter_out, 32'h0000_0009);

        // Scenario 2: periodic on ch1
        wr(2'd3, 32'h030);
        wr(2'd1, 32'd2);
        for (int k = 0; k < 8; k++) begin
            pulse(1);
            rd_ch = 2'd1;
            exp_c = (k % 2 == 0) ? 32'd1 : 32'd2;
            exp_o = ((((k + 1) / 2) % 2) == 1);
            #1 chk($sformatf("per_cnt%0d", k), counter_out, exp_c);
            chk($sformatf("per_out%0d", k), {31'h0, counter_OUT[1]}, {31'h0, exp_o});
            rd_ch = 2'd3;
            #1 if (counter_out[30]) n_pend++;
            clr(1);
        end
        chk("per_pend_cnt", 32'(n_pend), 32'd4);
        tick[1] = 1'b1; cyc(5); tick[1] = 1'b0; cyc(1);
        rd_ch = 2'd1;
        #1 chk("per_wide", counter_out, 32'd1);

        // Scenario 3: PWM on ch2, D=3 P=4
        wr(2'd3, 32'h500);
        wr(2'd2, 32'h0003_0004);
        for (int k = 0; k < 8; k++) begin
            pulse(2);
            rd_ch = 2'd2;
            exp_c = 32'((k + 1) % 4);
            exp_o = (exp_c < 32'd3);
            #1 chk($sformatf("pwm_cnt%0d", k), counter_out, exp_c);
            chk($sformatf("pwm_out%0d", k), {31'h0, counter_OUT[2]}, {31'h0, exp_o});
            rd_ch = 2'd3;
            #1 chk($sformatf("pwm_pend%0d", k), {31'h0, counter_out[31]}, {31'h0, exp_c == 32'd0});
            clr(2);
        end
        wr(2'd2, 32'h0000_0004);
        for (int k = 0; k < 4; k++) begin
            pulse(2);
            chk($sformatf("pwm_d0_%0d", k), {31'h0, counter_OUT[2]}, 32'h0);
        end
        wr(2'd2, 32'h0005_0004);
        for (int k = 0; k < 4; k++) begin
            pulse(2);
            chk($sformatf("pwm_d5_%0d", k), {31'h0, counter_OUT[2]}, 32'h1);
        end

        // Scenario 4: write vs tick, clear vs set
        wr(2'd3, 32'h001);
        wr(2'd0, 32'd5);
        tick[0] = 1'b1;
        wr(2'd0, 32'd7);
        cyc(1);
        tick[0] = 1'b0;
        cyc(1);
        rd_ch = 2'd0;
        #1 chk("wr_beats_tick", counter_out, 32'd7);
        pulse(0);
        chk("after_wr_tick", counter_out, 32'd6);
        clr(0);
        rd_ch = 2'd3;
        #1 chk("pend0_cleared", {31'h0, counter_out[29]}, 32'h0);
        wr(2'd0, 32'd1);
        tick[0] = 1'b1; irq_clr[0] = 1'b1;
        cyc(1);
        tick[0] = 1'b0; irq_clr[0] = 1'b0;
        cyc(1);
        chk("set_beats_clr", {31'h0, counter_out[29]}, 32'h1);
        chk("os_out_again", {31'h0, counter_OUT[0]}, 32'h1);

        // Scenario 5: disable freezes, reset clears
        wr(2'd0, 32'd10);
        pulse(0); pulse(0);
        rd_ch = 2'd0;
        #1 chk("dis_pre", counter_out, 32'd8);
        wr(2'd3, 32'h000);
        pulse(0); pulse(0); pulse(0);
        chk("dis_frozen", counter_out, 32'd8);
        wr(2'd3, 32'h008);
        chk("pre_rst_irq", {31'h0, irq}, 32'h1);
        RSTN = 1'b0;
        cyc(1);
        RSTN = 1'b1;
        for (int r = 0; r < 4; r++) begin
            rd_ch = 2'(r);
            #1 chk($sformatf("rst2_rd%0d", r), counter_out, 32'h0);
        end
        chk("rst2_out", {29'h0, counter_OUT}, 32'h0);
        chk("rst2_irq", {31'h0, irq}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/counter_mcx.md
Name: counter_mcx

Overview:
- Parametrised successor to the fixed 3-channel SoC counter unit: CH independent W-bit down/phase counters, each clocked by its own divider tick.
- Each channel runs one-shot, periodic or PWM mode, with a per-channel output and an interrupt-pending flag.
- Sits on the MIO bus beside the GPIO ports; the bus drives writes and reads back counts or status.
- The IRQ output feeds the CPU INT input.

Parameters:
- CH, 3: number of channels; 1 <= CH and 5*CH <= W.
- W, 32: counter, reload and bus data width.
- CW, 2: channel-select width; 2**CW > CH, so the index value CH is addressable.

Ports:
- clk  in  1  system clock; everything is on the rising edge.
- RSTN  in  1  synchronous active-low reset.
- counter_we  in  1  bus write strobe.
- counter_ch  in  CW  write target: 0..CH-1 selects a channel reload; CH selects the control register; above CH ignores the write.
- counter_val  in  W  write data.
- tick  in  CH  per-channel count enables from the clock divider; level signals, rising edge used.
- irq_clr  in  CH  per-channel pending clear, level.
- rd_ch  in  CW  read select.
- counter_out  out  W  read data, combinational.
- counter_OUT  out  CH  per-channel output levels, registered.
- irq  out  1  interrupt request, registered.

Behaviour:
Reset (RSTN=0 at a clk edge):
- Clears count, reload, ctrl, pend, tick_q, counter_OUT and irq to 0.
- counter_out then reads 0.
- Reset overrides every other input in that cycle.

Control register: 4 bits per channel i at counter_val[4i+3:4i].
- bit0 en, bits2:1 mode, bit3 ie.
- Control write: updates all CH ctrl fields.
- For each channel whose mode field changes: out<=0, and count<=reload (modes 00/01) or count<=0 (mode 10).
- Channels whose mode is unchanged keep count and out.

Reload write to channel i: reload[i]<=counter_val; count[i]<=counter_val (mode 10: count<=0); out[i]<=0.

Tick event:
- ev[i] = en[i] & tick[i] & ~tick_q[i].
- tick_q is registered every cycle, including when disabled.
- The count update happens at the same edge that first samples tick high; one update per rising tick regardless of pulse length.

Mode 00, one-shot:
- ev with count>1: count-=1.
- ev with count==1: count<=0, out<=1, pend<=1.
- ev with count==0: no change.
- out stays 1 until the next reload write or mode change.

Mode 01, periodic:
- reload==0: channel inert (no count change, no pend).
- ev with count>1: count-=1.
- ev with count<=1: count<=reload, out toggles, pend<=1.
- Resulting period = reload ticks per pend; out is a square wave of 2*reload ticks.

Mode 10, PWM: period P = reload[W/2-1:0], duty D = reload[W-1:W/2].
- P==0: count held at 0, out=0, no pend.
- Otherwise on ev: count <= (count==P-1) ? 0 : count+1.
- pend<=1 when wrapping to 0.
- out registered as (next count < D): D==0 gives always 0; D>=P gives always 1.

Mode 11, reserved: count held, out=0, no pend.

Disable (en=0): count and out frozen; no pend set.

Pending and IRQ:
- pend[i] cleared by irq_clr[i].
- If a set and a clear occur in the same cycle, set wins.
- irq <= |(pend_next & ie): irq rises in the same edge that sets pend.
- Clearing ie masks irq but keeps pend.

Simultaneous events:
- A reload write to channel i in the same cycle as ev[i]: write wins, tick dropped (tick_q still updates).
- A control write coinciding with ev: ev is evaluated with the new ctrl values.

Wrap and width:
- All arithmetic is unsigned W-bit.
- The one-shot and periodic down-count never goes below 0.

Readback:
- rd_ch<CH: count[rd_ch].
- rd_ch==CH: {pend[CH-1:0] in bits W-1:W-CH, zeros, ctrl in bits 4CH-1:0}.
- rd_ch>CH: 0.

Test Plan:
1. Reset, then ctrl=0x001 (ch0 en, one-shot), reload ch0=3, 4 tick0 pulses:
   - count reads 2,1,0,0.
   - counter_OUT[0] rises on the 3rd tick and pend[0]=1.
   - irq stays 0 (ie=0).
   - Set ie (ctrl=0x009): irq=1 on the next edge; irq_clr[0] -> irq=0.
2. ch1 periodic (ctrl=0x030), reload=2, 8 ticks:
   - counter_OUT[1] toggles every 2 ticks (4 toggles), pend set 4 times.
   - A 5-cycle-wide tick counts once.
3. ch2 PWM (ctrl=0x500), reload=0x0003_0004 (D=3, P=4), 8 ticks:
   - out pattern 1,1,0,1,1,1,0,1 with counts 1,2,3,0,1,2,3,0.
   - pend on each wrap.
   - D=0 gives out constant 0; D=5 gives constant 1.
4. Reload write to ch0 in the same cycle as a tick0 rising edge: count equals the written value, no decrement. irq_clr and pend-set in the same cycle: pend stays 1.
5. Mid-count: clear en, 3 ticks, then count unchanged. RSTN=0 for one edge mid-run:
   - all counts, ctrl, counter_OUT and irq are 0.
   - rd_ch=CH reads 0.
6. Readback with rd_ch=3 after scenario 1: {pend=001 at bits 31:29, ctrl=0x009}. rd_ch=4 and above reads 0 (CW>2 build with CH=3).
